bus_router: RTL and testbench

Parametrised data-bus router for the RISC-V core. It sits between the core's single load/store port and NUM_TARGETS memory-mapped slaves (RAM, IO, …). It decodes each word address against per-target base/mask regions and forwards the access as a one-hot select. It then waits for the selected target's acknowledge and returns a single response beat, signalling an error for unmapped addresses or targets that never acknowledge.

---
 rtl/bus_router_if.sv | 36 +++
 rtl/bus_router.sv | 109 ++++++++++
 tb/tb_bus_router.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/bus_router_if.sv
// bus_router_if: core-to-router request/response bus plus router-to-target access bus.
// Ports (signals):
//   req_valid/req_ready/req_addr/req_we/req_wdata/req_wstrb : core request handshake
//   tgt_sel/tgt_addr/tgt_we/tgt_wdata/tgt_wstrb             : one-hot target access
//   tgt_ack/tgt_rdata                                        : per-target acknowledge and read data
//   rsp_valid/rsp_rdata/rsp_err                              : single-beat response to the core
// Modports: slave = router side, master = core/target environment side.
interface bus_router_if #(
    parameter int NUM_TARGETS = 2,
    parameter int ADDR_W = 30
);
    logic                        req_valid;
    logic                        req_ready;
    logic [ADDR_W-1:0]           req_addr;
    logic                        req_we;
    logic [31:0]                 req_wdata;
    logic [3:0]                  req_wstrb;
    logic [NUM_TARGETS-1:0]      tgt_sel;
    logic [ADDR_W-1:0]           tgt_addr;
    logic                        tgt_we;
    logic [31:0]                 tgt_wdata;
    logic [3:0]                  tgt_wstrb;
    logic [NUM_TARGETS-1:0]      tgt_ack;
    logic [NUM_TARGETS*32-1:0]   tgt_rdata;
    logic                        rsp_valid;
    logic [31:0]                 rsp_rdata;
    logic                        rsp_err;
    modport slave (
        input  req_valid, req_addr, req_we, req_wdata, req_wstrb, tgt_ack, tgt_rdata,
        output req_ready, tgt_sel, tgt_addr, tgt_we, tgt_wdata, tgt_wstrb, rsp_valid, rsp_rdata, rsp_err
    );
    modport master (
        output req_valid, req_addr, req_we, req_wdata, req_wstrb, tgt_ack, tgt_rdata,
        input  req_ready, tgt_sel, tgt_addr, tgt_we, tgt_wdata, tgt_wstrb, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/bus_router.sv
// bus_router: decodes core word addresses to one of NUM_TARGETS regions and returns one response beat.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : bus_router_if.slave (core request, target access, response)
module bus_router #(
    parameter int NUM_TARGETS = 2,
    parameter int ADDR_W = 30,
    parameter logic [NUM_TARGETS*ADDR_W-1:0] REGION_BASE = {30'h3C00_0000, 30'h0000_0000},
    parameter logic [NUM_TARGETS*ADDR_W-1:0] REGION_MASK = {30'h3FFF_C000, 30'h3C00_0000},
    parameter int TIMEOUT = 15
) (
    input logic clk,
    input logic rst_n,
    bus_router_if.slave bus
);
    localparam int IDX_W = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state;
    state_t            state_nx;
    logic              hit;
    logic [IDX_W-1:0]  hit_idx;
    logic [IDX_W-1:0]  sel_idx;
    logic [CNT_W-1:0]  cnt;
    logic              ack_sel;
    logic              cnt_last;

    for (genvar i = 0; i < NUM_TARGETS; i++) begin : g_chk
        if ((REGION_BASE[i*ADDR_W +: ADDR_W] & ~REGION_MASK[i*ADDR_W +: ADDR_W]) != '0) begin : g_bad
            $fatal(1, "bus_router: region %0d base has bits outside its mask", i);
        end
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $fatal(1, "bus_router: TIMEOUT must be at least 1");
    end

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        hit = 1'b0;
        hit_idx = '0;
        for (int j = NUM_TARGETS - 1; j >= 0; j--) begin
            if ((bus.req_addr & REGION_MASK[j*ADDR_W +: ADDR_W]) == REGION_BASE[j*ADDR_W +: ADDR_W]) begin
                hit = 1'b1;
                hit_idx = IDX_W'(j);
            end
        end
    end

    assign ack_sel  = bus.tgt_ack[sel_idx];
    assign cnt_last = cnt == CNT_W'(TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Ack takes priority over the timeout in the same cycle.
    always_comb begin
        state_nx = (state == IDLE)   ? (bus.req_valid ? (hit ? ACCESS : RESP) : IDLE) :
                   (state == ACCESS) ? ((ack_sel || cnt_last) ? RESP : ACCESS) :
                                       IDLE;
    end

    always_comb begin
        bus.req_ready = state == IDLE;
        bus.rsp_valid = state == RESP;
        bus.tgt_sel   = (state == ACCESS) ? NUM_TARGETS'(1) << sel_idx : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_idx       <= '0;
            cnt           <= '0;
            bus.tgt_addr  <= '0;
            bus.tgt_we    <= 1'b0;
            bus.tgt_wdata <= '0;
            bus.tgt_wstrb <= '0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else if (state == IDLE && bus.req_valid) begin
            if (hit) begin
                sel_idx       <= hit_idx;
                cnt           <= '0;
                bus.tgt_addr  <= bus.req_addr;
                bus.tgt_we    <= bus.req_we;
                bus.tgt_wdata <= bus.req_wdata;
                bus.tgt_wstrb <= bus.req_wstrb;
            end else begin
                bus.rsp_rdata <= '0;
                bus.rsp_err   <= 1'b1;
            end
        end else if (state == ACCESS) begin
            if (ack_sel) begin
                bus.rsp_rdata <= bus.tgt_we ? 32'h0 : bus.tgt_rdata[32*sel_idx +: 32];
                bus.rsp_err   <= 1'b0;
            end else if (cnt_last) begin
                bus.rsp_rdata <= '0;
                bus.rsp_err   <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bus_router.sv
// tb_bus_router: directed scoreboard bench for bus_router with default regions and TIMEOUT = 15.
module tb_bus_router;
    localparam int NT = 2;
    localparam int AW = 30;
    localparam int TO = 15;

    typedef struct {
        logic [31:0]   rdata;
        logic          err;
        int            lat;
        logic [NT-1:0] sel;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    bus_router_if #(.NUM_TARGETS(NT), .ADDR_W(AW)) bus ();

    bus_router #(.NUM_TARGETS(NT), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decode of the default memory map: RAM 0x0000_0000.., IO 0xF000_0000.. (byte).
    function automatic int decode(input logic [AW-1:0] a);
        if ((a & 30'h3C00_0000) == 30'h0000_0000) return 0;
        if ((a & 30'h3FFF_C000) == 30'h3C00_0000) return 1;
        return -1;
    endfunction

    task automatic run(input string tag, input logic [AW-1:0] addr, input logic we,
                       input logic [31:0] wdata, input logic [3:0] wstrb, input int ack_k,
                       input logic [31:0] rd0, input logic [31:0] rd1, input logic spam1);
        exp_t e;
        exp_t x;
        int   t;
        bit   done;
        t = decode(addr);
        e.sel = (t < 0) ? '0 : NT'(1) << t;
        if (t < 0) begin
            e.err = 1'b1; e.rdata = 32'h0; e.lat = 1;
        end else if (ack_k >= 1 && ack_k <= TO) begin
            e.err = 1'b0; e.rdata = we ? 32'h0 : (t == 0 ? rd0 : rd1); e.lat = ack_k + 1;
        end else begin
            e.err = 1'b1; e.rdata = 32'h0; e.lat = TO + 1;
        end
        sb.push_back(e);
        chk({tag, " ready_idle"}, bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_we    = we;
        bus.req_wdata = wdata;
        bus.req_wstrb = wstrb;
        bus.tgt_rdata = {rd1, rd0};
        tick();
        bus.req_valid = 1'b0;
        bus.req_addr  = ~addr;
        bus.req_we    = ~we;
        bus.req_wdata = ~wdata;
        bus.req_wstrb = ~wstrb;
        done = 1'b0;
        for (int n = 1; n <= TO + 8 && !done; n++) begin
            if (bus.rsp_valid) begin
                done = 1'b1;
                chk({tag, " sb_depth"}, 64'(sb.size()), 64'd1);
                if (sb.size() != 0) begin
                    x = sb.pop_front();
                    chk({tag, " latency"}, 64'(n), 64'(x.lat));
                    chk({tag, " rdata"}, bus.rsp_rdata, x.rdata);
                    chk({tag, " err"}, bus.rsp_err, x.err);
                    chk({tag, " sel_resp"}, bus.tgt_sel, 0);
                    chk({tag, " ready_resp"}, bus.req_ready, 0);
                end
            end else begin
                chk({tag, " sel"}, bus.tgt_sel, e.sel);
                chk({tag, " ready_busy"}, bus.req_ready, 0);
                chk({tag, " addr"}, bus.tgt_addr, addr);
                chk({tag, " we"}, bus.tgt_we, we);
                chk({tag, " wdata"}, bus.tgt_wdata, wdata);
                chk({tag, " wstrb"}, bus.tgt_wstrb, wstrb);
                bus.tgt_ack = (spam1 ? 2'b10 : 2'b00) | ((t >= 0 && n == ack_k) ? e.sel : 2'b00);
                tick();
            end
        end
        bus.tgt_ack = '0;
        chk({tag, " rsp_seen"}, done, 1);
        tick();
        chk({tag, " rsp_pulse_end"}, bus.rsp_valid, 0);
        chk({tag, " ready_after"}, bus.req_ready, 1);
        chk({tag, " err_hold"}, bus.rsp_err, e.err);
        chk({tag, " rdata_hold"}, bus.rsp_rdata, e.rdata);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_we    = 1'b0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;
        bus.tgt_ack   = '0;
        bus.tgt_rdata = '0;
        tick();
        tick();
        chk("reset ready", bus.req_ready, 1);
        chk("reset rsp_valid", bus.rsp_valid, 0);
        chk("reset sel", bus.tgt_sel, 0);
        chk("reset err", bus.rsp_err, 0);
        chk("reset rdata", bus.rsp_rdata, 0);
        chk("reset addr", bus.tgt_addr, 0);
        rst_n = 1'b1;
        tick();

        run("rd_t0", 30'h0000_0100, 1'b0, 32'h0, 4'hF, 1, 32'h1234_5678, 32'h0, 1'b0);
        run("wr_t1", 30'h3C00_0004, 1'b1, 32'hA5A5_A5A5, 4'b0011, 3, 32'h1111_1111, 32'h2222_2222, 1'b0);
        run("miss", 30'h2000_0000, 1'b0, 32'h0, 4'h0, 1, 32'hFFFF_FFFF, 32'hEEEE_EEEE, 1'b0);

        bus.req_valid = 1'b1;
        bus.req_addr  = 30'h0000_0040;
        bus.req_we    = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        chk("rst_mid pre_sel", bus.tgt_sel, 2'b01);
        rst_n = 1'b0;
        tick();
        chk("rst_mid sel", bus.tgt_sel, 0);
        chk("rst_mid rsp_valid", bus.rsp_valid, 0);
        chk("rst_mid ready", bus.req_ready, 1);
        chk("rst_mid addr", bus.tgt_addr, 0);
        chk("rst_mid err", bus.rsp_err, 0);
        chk("rst_mid rdata", bus.rsp_rdata, 0);
        rst_n = 1'b1;
        for (int n = 0; n < TO + 3; n++) begin
            tick();
            chk("rst_mid no_rsp", bus.rsp_valid, 0);
        end

        run("timeout", 30'h0000_0200, 1'b0, 32'h0, 4'hF, 0, 32'h5555_5555, 32'hDEAD_BEEF, 1'b1);
        run("ack_last", 30'h0000_0300, 1'b0, 32'h0, 4'hF, TO, 32'hCAFE_F00D, 32'h0, 1'b0);
        run("rd_t1_top", 30'h3C00_3FFF, 1'b0, 32'h0, 4'hF, 2, 32'h0, 32'h0BAD_F00D, 1'b0);
        run("wr_t0_top", 30'h03FF_FFFF, 1'b1, 32'h0F0F_0F0F, 4'b1100, 1, 32'h7777_7777, 32'h0, 1'b0);
        run("miss_io_edge", 30'h3C00_4000, 1'b0, 32'h0, 4'hF, 1, 32'h3333_3333, 32'h4444_4444, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
